// File: rtl/fetch_queue_if.sv
// Fetch front end bus: instruction-memory request/response, decode-side
// valid/ready handshake and the execute-stage redirect.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // fetch_queue side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  // memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: in-order word requests to instruction memory,
// credit-limited so returned words always fit in a DEPTH-entry {pc, data}
// FIFO, presented to decode over valid/ready; redirect flushes and restarts.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ, outst, disc;
  logic [CW-1:0] outst_next;
  logic [CW:0]   credit_used;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [31:0]   redirect_aligned;
  logic          accept, pop, push;

  assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;
  assign credit_used      = {1'b0, occ} + {1'b0, outst};

  // Request issue depends only on registered counts, reset and redirect;
  // outstanding includes in-flight words still to be discarded.
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid &&
                              (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign bus.instr_valid = (occ != '0);
  assign bus.instr_data  = data_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

  assign accept     = bus.imem_req_valid && bus.imem_req_ready;
  assign pop        = bus.instr_valid && bus.instr_ready;
  assign push       = bus.imem_rsp_valid && !bus.redirect_valid && (disc == '0);
  assign outst_next = outst + CW'(accept) - CW'(bus.imem_rsp_valid);

  // Control state: PCs, pointers and counters; redirect overrides everything
  // except the outstanding count, which must keep tracking in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      disc     <= '0;
    end else begin
      outst <= outst_next;
      if (bus.redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
        disc     <= outst_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rsp_valid) begin
          if (disc != '0) begin
            disc <= disc - CW'(1);
          end else begin
            rsp_pc <= rsp_pc + 32'd4;
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are qualified by occ so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      data_mem[wr_ptr] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with variable
// latency, expected {pc, data} scoreboard filled at request acceptance.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } instr_t;

  logic clk;
  logic rst_n;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  mreq_t       mem_q [$];
  instr_t      exp_q [$];
  int unsigned cyc;
  int unsigned lat;
  int          tb_occ;
  int          tb_outst;
  int          tb_disc;
  int          pops;
  logic [31:0] exp_fetch;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234} + {a[7:0], 24'h0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the reference model for the coming rising edge.
  task automatic step(input logic ird, input logic rdr, input logic [31:0] rpc,
                      input int unsigned rdy_pct);
    logic        rsp, acc, exp_rv, do_pop;
    logic [31:0] word;
    @(negedge clk);
    cyc++;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (rsp) begin
      bus.imem_rsp_data = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_data = 32'hDEAD_BEEF;
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.instr_ready    = ird;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    #1;
    exp_rv = !rdr && (tb_occ + tb_outst < DEPTH);
    check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (bus.imem_req_valid) check_eq("req_addr", bus.imem_req_addr, exp_fetch);
    check_eq("instr_valid", 32'(bus.instr_valid), 32'(tb_occ != 0));
    do_pop = (tb_occ != 0) && ird;
    if (bus.instr_valid && exp_q.size() > 0) begin
      check_eq("instr_pc", bus.instr_pc, exp_q[0].pc);
      check_eq("instr_data", bus.instr_data, exp_q[0].data);
    end
    if (do_pop && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pops++;
    end
    acc = bus.imem_req_valid && bus.imem_req_ready;
    if (acc) begin
      word = mem_word(bus.imem_req_addr);
      mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: bus.imem_req_addr, data: word});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rsp) begin
      if (tb_disc > 0) tb_disc--;
      else if (!rdr) tb_occ++;
    end
    if (do_pop) tb_occ--;
    tb_outst = tb_outst + int'(acc) - int'(rsp);
    if (rdr) begin
      tb_occ = 0;
      exp_q.delete();
      tb_disc   = tb_outst;
      exp_fetch = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic run(input int n, input logic ird, input int unsigned rdy_pct);
    for (int i = 0; i < n; i++) step(ird, 1'b0, 32'h0, rdy_pct);
  endtask

  task automatic redirect(input logic [31:0] rpc, input logic ird);
    step(ird, 1'b1, rpc, 100);
  endtask

  initial begin
    int start;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 1;
    tb_occ   = 0;
    tb_outst = 0;
    tb_disc  = 0;
    pops     = 0;
    exp_fetch = 32'h0000_0000;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset held: nothing requested, nothing presented.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming with 1-cycle memory and decode always ready.
    lat = 1;
    run(20, 1'b1, 100);

    // Decode stalled: credits run out with the FIFO full, head held.
    run(15, 1'b0, 100);
    check_eq("stall_outstanding", 32'(tb_outst), 32'd0);
    run(10, 1'b1, 100);

    // 3-cycle memory, toggling request ready, random decode ready.
    lat = 3;
    start = pops;
    for (int i = 0; i < 400 && pops - start < 20; i++)
      step(1'($urandom_range(1)), 1'b0, 32'h0, 50);
    check_eq("lat3_pops", 32'(pops - start >= 20), 32'd1);

    // Redirect with words in flight and entries buffered.
    redirect(32'h0000_0040, 1'b1);
    run(5, 1'b0, 100);
    redirect(32'h0000_0103, 1'b0);
    run(12, 1'b1, 100);

    // Redirect coincident with a head handshake and a response.
    lat = 1;
    run(6, 1'b1, 100);
    redirect(32'h0000_0080, 1'b1);
    run(6, 1'b1, 100);

    // Back-to-back redirects, then fetch address wrap.
    lat = 2;
    run(3, 1'b1, 100);
    redirect(32'h0000_0200, 1'b1);
    redirect(32'h0000_0300, 1'b1);
    run(10, 1'b1, 100);
    redirect(32'hFFFF_FFF4, 1'b1);
    run(10, 1'b1, 100);

    // Drain: stop requesting and empty everything.
    for (int i = 0; i < 200 && (tb_occ != 0 || tb_outst != 0 || exp_q.size() != 0); i++)
      step(1'b1, 1'b0, 32'h0, 0);
    check_eq("drain_done", 32'(tb_occ + tb_outst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
